// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT/INTT controllers.
// The butterfly latency macros normally come from defines.v; standard
// datapath depths are used when that file is not part of the compile.
`ifndef INTMUL_DELAY
`define INTMUL_DELAY 2
`endif
`ifndef MODRED_DELAY
`define MODRED_DELAY 1
`endif

package ntt_pkg;

    localparam int RING_SIZE  = 256;
    localparam int LOG_N      = $clog2(RING_SIZE);
    localparam int PIPE_DELAY = `INTMUL_DELAY + `MODRED_DELAY;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        SCALE,
        FLUSH,
        DONE
    } ntt_state_t;

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register used to line write-back strobes and addresses
// up with the butterfly datapath latency. Reset clears every tap so no stale
// write can leak out after an abort.
module ntt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift one tap per cycle, clearing the whole line on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/intt_controller.sv
// Address and control sequencer for an in-place inverse NTT: LOG_N
// Gentleman-Sande butterfly stages followed by one N^-1 scaling pass.
// Read-side outputs are registered; write-back outputs are the read-side
// outputs pushed through a PIPE_DELAY-deep delay line.
module intt_controller #(
    parameter int  RING_SIZE  = ntt_pkg::RING_SIZE,
    parameter int  PIPE_DELAY = ntt_pkg::PIPE_DELAY,
    localparam int LOG_N      = $clog2(RING_SIZE),
    localparam int STAGE_W    = $clog2(LOG_N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [LOG_N-1:0]   rd_addr_a,
    output logic [LOG_N-1:0]   rd_addr_b,
    output logic [LOG_N-2:0]   tw_idx,
    output logic               bf_mode,
    output logic [STAGE_W-1:0] stage,
    output logic               wr_en,
    output logic [LOG_N-1:0]   wr_addr_a,
    output logic [LOG_N-1:0]   wr_addr_b
);

    import ntt_pkg::*;

    localparam int TW_W = LOG_N - 1;
    localparam int S_W  = $clog2(LOG_N);
    localparam int D_W  = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;
    localparam int WB_W = 1 + 2 * LOG_N;

    localparam logic [LOG_N-2:0] J_LAST = (LOG_N - 1)'(RING_SIZE / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST = S_W'(LOG_N - 1);
    localparam logic [D_W-1:0]   D_LAST = D_W'(PIPE_DELAY - 1);

    typedef struct packed {
        logic [LOG_N-1:0] a;
        logic [LOG_N-1:0] b;
        logic [TW_W-1:0]  tw;
    } pair_t;

    // Butterfly pair j of stage s. The two operands differ only in bit
    // p = LOG_N-1-s (span m = 2^p); the pair address is j with a zero bit
    // inserted at position p, and the twiddle is the in-group offset k
    // scaled by 2^s.
    function automatic pair_t bf_pair(input logic [S_W-1:0] s, input logic [LOG_N-2:0] j);
        pair_t            r;
        int               p;
        logic [LOG_N-1:0] jw;
        logic [LOG_N-1:0] low_mask;
        logic [LOG_N-1:0] span;
        p        = LOG_N - 1 - int'(s);
        jw       = {1'b0, j};
        span     = LOG_N'(1) << p;
        low_mask = span - LOG_N'(1);
        r.a      = ((jw & ~low_mask) << 1) | (jw & low_mask);
        r.b      = r.a | span;
        r.tw     = TW_W'((jw & low_mask) << s);
        return r;
    endfunction

    // Scaling pass walks adjacent coefficient pairs (2j, 2j+1).
    function automatic pair_t scale_pair(input logic [LOG_N-2:0] j);
        pair_t r;
        r.a  = {j, 1'b0};
        r.b  = {j, 1'b1};
        r.tw = '0;
        return r;
    endfunction

    ntt_state_t       state;
    logic [S_W-1:0]   s_cnt;
    logic [LOG_N-2:0] j_cnt;
    logic [D_W-1:0]   d_cnt;
    logic [WB_W-1:0]  wb_bus;

    // Sequencer: state, loop counters and registered read-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            j_cnt     <= '0;
            d_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
            bf_mode   <= 1'b0;
            stage     <= '0;
        end else begin
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
            bf_mode   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        s_cnt <= '0;
                        j_cnt <= '0;
                        busy  <= 1'b1;
                        stage <= '0;
                        rd_en <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_idx} <= bf_pair('0, '0);
                    end
                end
                RUN: begin
                    if (j_cnt == J_LAST) begin
                        state <= DRAIN;
                        d_cnt <= '0;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                        rd_en <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_idx} <= bf_pair(s_cnt, j_cnt + 1'b1);
                    end
                end
                DRAIN: begin
                    if (d_cnt == D_LAST) begin
                        j_cnt <= '0;
                        rd_en <= 1'b1;
                        if (s_cnt == S_LAST) begin
                            state   <= SCALE;
                            stage   <= STAGE_W'(LOG_N);
                            bf_mode <= 1'b1;
                            {rd_addr_a, rd_addr_b, tw_idx} <= scale_pair('0);
                        end else begin
                            state <= RUN;
                            s_cnt <= s_cnt + 1'b1;
                            stage <= STAGE_W'(s_cnt) + 1'b1;
                            {rd_addr_a, rd_addr_b, tw_idx} <= bf_pair(s_cnt + 1'b1, '0);
                        end
                    end else begin
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                SCALE: begin
                    if (j_cnt == J_LAST) begin
                        state <= FLUSH;
                        d_cnt <= '0;
                    end else begin
                        j_cnt   <= j_cnt + 1'b1;
                        rd_en   <= 1'b1;
                        bf_mode <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_idx} <= scale_pair(j_cnt + 1'b1);
                    end
                end
                FLUSH: begin
                    if (d_cnt == D_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        d_cnt <= d_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    stage <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    stage <= '0;
                end
            endcase
        end
    end

    ntt_delay_line #(
        .WIDTH (WB_W),
        .DEPTH (PIPE_DELAY)
    ) u_wb_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({rd_en, rd_addr_a, rd_addr_b}),
        .dout  (wb_bus)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wb_bus;

endmodule

// File: tb/tb_intt_controller.sv
// Bench for intt_controller at N=8, PIPE_DELAY=3. The expected per-cycle
// schedule is computed from the transform's index arithmetic (m, k, g) and
// compared cycle by cycle, with random start noise, random gaps and resets.
module tb_intt_controller;

    localparam int N       = 8;
    localparam int PD      = 3;
    localparam int LOG_N   = 3;
    localparam int RUN_LEN = 1 + LOG_N * (N / 2 + PD) + N / 2 + PD;  // done cycle

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [1:0] tw_idx;
    logic       bf_mode;
    logic [1:0] stage;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [2:0] wr_addr_b;

    int vectors     = 0;
    int miscompares = 0;

    int e_rd   [0:RUN_LEN];
    int e_a    [0:RUN_LEN];
    int e_b    [0:RUN_LEN];
    int e_tw   [0:RUN_LEN];
    int e_mode [0:RUN_LEN];
    int e_stage[0:RUN_LEN];

    always #5 clk = ~clk;

    intt_controller #(
        .RING_SIZE  (N),
        .PIPE_DELAY (PD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .bf_mode   (bf_mode),
        .stage     (stage),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference schedule for one transform, indexed by cycle after start.
    function automatic void build_model();
        int c;
        for (int i = 0; i <= RUN_LEN; i++) begin
            e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0; e_mode[i] = 0; e_stage[i] = 0;
        end
        c = 1;
        for (int s = 0; s < LOG_N; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                int m;
                m          = N >> (s + 1);
                e_rd[c]    = 1;
                e_a[c]     = (j / m) * 2 * m + (j % m);
                e_b[c]     = e_a[c] + m;
                e_tw[c]    = (j % m) << s;
                e_stage[c] = s;
                c++;
            end
            c += PD;
        end
        for (int j = 0; j < N / 2; j++) begin
            e_rd[c]    = 1;
            e_a[c]     = 2 * j;
            e_b[c]     = 2 * j + 1;
            e_mode[c]  = 1;
            e_stage[c] = LOG_N;
            c++;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input int c);
        string t;
        int    w;
        t = $sformatf("cyc%0d", c);
        w = c - PD;
        chk({t, " busy"},    busy,      1);
        chk({t, " done"},    done,      (c == RUN_LEN) ? 1 : 0);
        chk({t, " rd_en"},   rd_en,     e_rd[c]);
        chk({t, " rd_a"},    rd_addr_a, e_a[c]);
        chk({t, " rd_b"},    rd_addr_b, e_b[c]);
        chk({t, " tw_idx"},  tw_idx,    e_tw[c]);
        chk({t, " bf_mode"}, bf_mode,   e_mode[c]);
        if (e_rd[c] != 0) chk({t, " stage"}, stage, e_stage[c]);
        chk({t, " wr_en"},   wr_en,     (w >= 1) ? e_rd[w] : 0);
        chk({t, " wr_a"},    wr_addr_a, (w >= 1) ? e_a[w]  : 0);
        chk({t, " wr_b"},    wr_addr_b, (w >= 1) ? e_b[w]  : 0);
    endtask

    task automatic check_idle(input string t, input bit with_stage);
        chk({t, " busy"},    busy,      0);
        chk({t, " done"},    done,      0);
        chk({t, " rd_en"},   rd_en,     0);
        chk({t, " rd_a"},    rd_addr_a, 0);
        chk({t, " rd_b"},    rd_addr_b, 0);
        chk({t, " tw_idx"},  tw_idx,    0);
        chk({t, " bf_mode"}, bf_mode,   0);
        if (with_stage) chk({t, " stage"}, stage, 0);
        chk({t, " wr_en"},   wr_en,     0);
        chk({t, " wr_a"},    wr_addr_a, 0);
        chk({t, " wr_b"},    wr_addr_b, 0);
    endtask

    task automatic idle_gap(input int cycles);
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            check_idle("gap", 1'b0);
        end
    endtask

    // mode 0: random start noise while busy (start forced in the done cycle)
    // mode 1: start held high throughout. abort_at > 0 resets in that cycle.
    task automatic run_transform(input int mode, input int abort_at);
        start = 1'b1;
        for (int c = 1; c <= RUN_LEN; c++) begin
            step();
            check_cycle(c);
            if (c == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                step();
                check_idle("abort+1", 1'b1);
                reset = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    step();
                    check_idle("post-abort", 1'b1);
                end
                return;
            end
            if (mode == 1)            start = 1'b1;
            else if (c == RUN_LEN)    start = 1'b1;
            else                      start = 1'($urandom_range(0, 1));
        end
        if (mode == 0) start = 1'b0;
        else           start = 1'b1;
        step();
        chk("end busy",  busy,  0);
        chk("end done",  done,  0);
        chk("end rd_en", rd_en, 0);
        chk("end wr_en", wr_en, 0);
        step();
        if (mode == 0) begin
            chk("after busy",  busy,  0);
            chk("after rd_en", rd_en, 0);
        end else begin
            chk("restart busy",  busy,      1);
            chk("restart rd_en", rd_en,     e_rd[1]);
            chk("restart rd_a",  rd_addr_a, e_a[1]);
            chk("restart rd_b",  rd_addr_b, e_b[1]);
            reset = 1'b1;
            start = 1'b0;
            step();
            check_idle("restart reset", 1'b1);
            reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        build_model();
        repeat (3) step();
        check_idle("in reset", 1'b1);
        reset = 1'b0;
        step();
        check_idle("after reset", 1'b1);

        run_transform(0, 0);
        idle_gap($urandom_range(0, 4));
        run_transform(1, 0);
        idle_gap($urandom_range(1, 4));
        run_transform(0, 10);
        run_transform(0, 0);
        idle_gap($urandom_range(0, 4));
        run_transform(0, $urandom_range(2, RUN_LEN - 2));
        for (int r = 0; r < 3; r++) begin
            idle_gap($urandom_range(0, 5));
            run_transform(0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
